// File: rtl/song_recorder.sv
// Live key-press recorder: turns note_on/note_off/beat activity into song RAM entries
// of {rest, note, duration, 3'b000}, closing the session on record fall or a full RAM.
module song_recorder #(
   parameter int ADDR_WIDTH = 7,
   parameter int NOTE_WIDTH = 6,
   parameter int DUR_WIDTH  = 6
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  beat,
   input  logic                                  record,
   input  logic                                  note_on,
   input  logic                                  note_off,
   input  logic [NOTE_WIDTH-1:0]                 note_in,
   output logic                                  write_enable,
   output logic [ADDR_WIDTH-1:0]                 write_address,
   output logic [NOTE_WIDTH+DUR_WIDTH+3:0]       write_payload,
   output logic                                  done_recording,
   output logic [ADDR_WIDTH-1:0]                 last_address,
   output logic                                  recording
);

   typedef enum logic [2:0] {IDLE, ARMED, NOTE, GAP, FULL} state_t;

   state_t                          state, state_n;
   logic [ADDR_WIDTH-1:0]           ptr, ptr_n;
   logic [NOTE_WIDTH-1:0]           note_q, note_n;
   logic [DUR_WIDTH-1:0]            cnt, cnt_n;
   logic                            record_q;

   logic                            we_n;
   logic [ADDR_WIDTH-1:0]           waddr_n;
   logic [NOTE_WIDTH+DUR_WIDTH+3:0] wpay_n;
   logic                            done_n;
   logic [ADDR_WIDTH-1:0]           last_n;

   logic                            key_on;
   logic [DUR_WIDTH-1:0]            step_cnt;
   logic [DUR_WIDTH-1:0]            dur_ent;
   logic [NOTE_WIDTH+DUR_WIDTH+3:0] note_pay;
   logic [NOTE_WIDTH+DUR_WIDTH+3:0] rest_pay;

   always_comb begin
      key_on   = note_on && (note_in != '0);
      // the counter never rests at the saturation value, so this cannot overflow
      step_cnt = cnt + DUR_WIDTH'(beat);
      dur_ent  = (step_cnt == '0) ? DUR_WIDTH'(1) : step_cnt;
      note_pay = {1'b0, note_q, dur_ent, 3'b000};
      rest_pay = {1'b1, {NOTE_WIDTH{1'b0}}, step_cnt, 3'b000};

      state_n = state;
      ptr_n   = ptr;
      note_n  = note_q;
      cnt_n   = cnt;
      we_n    = 1'b0;
      waddr_n = ptr;
      wpay_n  = '0;
      done_n  = 1'b0;
      last_n  = last_address;

      case (state)
         IDLE: begin
            if (record && !record_q) begin
               we_n    = 1'b1;
               waddr_n = '0;
               wpay_n  = {1'b1, {(NOTE_WIDTH+DUR_WIDTH+3){1'b0}}};
               cnt_n   = '0;
               state_n = ARMED;
            end
         end
         ARMED: begin
            if (!record) begin
               done_n  = 1'b1;
               last_n  = ptr - ADDR_WIDTH'(1);
               state_n = IDLE;
            end else if (key_on) begin
               note_n  = note_in;
               cnt_n   = '0;
               state_n = NOTE;
            end
         end
         NOTE: begin
            if (!record) begin
               we_n    = 1'b1;
               wpay_n  = note_pay;
               done_n  = 1'b1;
               last_n  = ptr;
               state_n = IDLE;
            end else if (key_on) begin
               we_n    = 1'b1;
               wpay_n  = note_pay;
               note_n  = note_in;
               cnt_n   = '0;
            end else if (note_off) begin
               we_n    = 1'b1;
               wpay_n  = note_pay;
               cnt_n   = '0;
               state_n = GAP;
            end else if (step_cnt == '1) begin
               we_n    = 1'b1;
               wpay_n  = note_pay;
               cnt_n   = '0;
            end else begin
               cnt_n   = step_cnt;
            end
         end
         GAP: begin
            if (!record) begin
               done_n  = 1'b1;
               last_n  = ptr - ADDR_WIDTH'(1);
               state_n = IDLE;
            end else if (key_on) begin
               we_n    = (step_cnt != '0);
               wpay_n  = rest_pay;
               note_n  = note_in;
               cnt_n   = '0;
               state_n = NOTE;
            end else if (step_cnt == '1) begin
               we_n    = 1'b1;
               wpay_n  = rest_pay;
               cnt_n   = '0;
            end else begin
               cnt_n   = step_cnt;
            end
         end
         FULL: begin
            if (!record) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // a write into the top address closes the session regardless of the trigger
      if (we_n) begin
         ptr_n = waddr_n + ADDR_WIDTH'(1);
         if (waddr_n == '1) begin
            done_n  = 1'b1;
            last_n  = waddr_n;
            state_n = record ? FULL : IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         ptr            <= '0;
         note_q         <= '0;
         cnt            <= '0;
         record_q       <= 1'b0;
         write_enable   <= 1'b0;
         write_address  <= '0;
         write_payload  <= '0;
         done_recording <= 1'b0;
         last_address   <= '0;
         recording      <= 1'b0;
      end else begin
         state          <= state_n;
         ptr            <= ptr_n;
         note_q         <= note_n;
         cnt            <= cnt_n;
         record_q       <= record;
         write_enable   <= we_n;
         if (we_n) begin
            write_address <= waddr_n;
            write_payload <= wpay_n;
         end
         done_recording <= done_n;
         last_address   <= last_n;
         recording      <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_song_recorder.sv
// Scoreboard bench for song_recorder: directed sessions push expected writes and
// session closes; a negedge monitor pops and compares whatever the DUT emits.
module tb_song_recorder;

   logic        clk;
   logic        reset;
   logic        beat;
   logic        record;
   logic        note_on;
   logic        note_off;
   logic [5:0]  note_in;
   logic        write_enable;
   logic [6:0]  write_address;
   logic [15:0] write_payload;
   logic        done_recording;
   logic [6:0]  last_address;
   logic        recording;

   int compared   = 0;
   int mismatched = 0;

   logic [22:0] exp_wr[$];
   logic [6:0]  exp_done[$];

   song_recorder #(.ADDR_WIDTH(7), .NOTE_WIDTH(6), .DUR_WIDTH(6)) dut (
      .clk            (clk),
      .reset          (reset),
      .beat           (beat),
      .record         (record),
      .note_on        (note_on),
      .note_off       (note_off),
      .note_in        (note_in),
      .write_enable   (write_enable),
      .write_address  (write_address),
      .write_payload  (write_payload),
      .done_recording (done_recording),
      .last_address   (last_address),
      .recording      (recording)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] pl(input logic r, input logic [5:0] n, input logic [5:0] d);
      return {r, n, d, 3'b000};
   endfunction

   task automatic push_wr(input logic [6:0] a, input logic [15:0] p);
      exp_wr.push_back({a, p});
   endtask

   task automatic push_done(input logic [6:0] a);
      exp_done.push_back(a);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      compared++;
      if (got !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic step(input logic b, input logic on, input logic off, input logic [5:0] n);
      beat = b; note_on = on; note_off = off; note_in = n;
      @(posedge clk); #1;
      beat = 1'b0; note_on = 1'b0; note_off = 1'b0; note_in = '0;
   endtask

   task automatic idle(input int unsigned k);
      for (int unsigned i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 6'd0);
   endtask

   task automatic beats(input int unsigned k);
      for (int unsigned i = 0; i < k; i++) step(1'b1, 1'b0, 1'b0, 6'd0);
   endtask

   task automatic set_rec(input logic v);
      record = v;
      step(1'b0, 1'b0, 1'b0, 6'd0);
   endtask

   // monitor
   always @(negedge clk) begin
      logic [22:0] e;
      logic [6:0]  d;
      if (write_enable) begin
         compared++;
         if (exp_wr.size() == 0) begin
            mismatched++;
            $display("FAIL write_unexpected: got addr=%0d payload=%h, required no write",
                     write_address, write_payload);
         end else begin
            e = exp_wr.pop_front();
            if ({write_address, write_payload} !== e) begin
               mismatched++;
               $display("FAIL write: got addr=%0d payload=%h, required addr=%0d payload=%h",
                        write_address, write_payload, e[22:16], e[15:0]);
            end
         end
      end
      if (done_recording) begin
         compared++;
         if (exp_done.size() == 0) begin
            mismatched++;
            $display("FAIL done_unexpected: got last_address=%0d, required no done",
                     last_address);
         end else begin
            d = exp_done.pop_front();
            if (last_address !== d) begin
               mismatched++;
               $display("FAIL done: got last_address=%0d, required %0d", last_address, d);
            end
         end
      end
   end

   initial begin
      logic [5:0] n;
      reset = 1'b1; record = 1'b0; beat = 1'b0;
      note_on = 1'b0; note_off = 1'b0; note_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_we",   32'(write_enable),   32'd0);
      chk("reset_done", 32'(done_recording), 32'd0);
      chk("reset_last", 32'(last_address),   32'd0);
      chk("reset_rec",  32'(recording),      32'd0);
      reset = 1'b0;
      idle(2);

      // 1: empty session
      push_wr(7'd0, 16'h8000);
      set_rec(1'b1);
      idle(3);
      chk("t1_recording", 32'(recording), 32'd1);
      push_done(7'd0);
      set_rec(1'b0);
      idle(2);
      chk("t1_idle", 32'(recording), 32'd0);

      // 2: note, rest, note, flush
      push_wr(7'd0, 16'h8000);
      set_rec(1'b1);
      step(1'b0, 1'b1, 1'b0, 6'd23);
      beats(5);
      push_wr(7'd1, pl(1'b0, 6'd23, 6'd5));
      step(1'b0, 1'b0, 1'b1, 6'd0);
      beats(10);
      push_wr(7'd2, pl(1'b1, 6'd0, 6'd10));
      step(1'b0, 1'b1, 1'b0, 6'd22);
      beats(5);
      push_wr(7'd3, pl(1'b0, 6'd22, 6'd5));
      push_done(7'd3);
      set_rec(1'b0);
      idle(2);

      // 3: minimum duration, coincident beat, legato, ignored strobes, zero-length flush
      push_wr(7'd0, 16'h8000);
      set_rec(1'b1);
      step(1'b0, 1'b0, 1'b1, 6'd0);
      beats(3);
      step(1'b0, 1'b1, 1'b0, 6'd0);
      step(1'b0, 1'b1, 1'b0, 6'd12);
      push_wr(7'd1, pl(1'b0, 6'd12, 6'd1));
      step(1'b0, 1'b0, 1'b1, 6'd0);
      step(1'b0, 1'b1, 1'b0, 6'd12);
      beats(2);
      push_wr(7'd2, pl(1'b0, 6'd12, 6'd3));
      step(1'b1, 1'b0, 1'b1, 6'd0);
      step(1'b0, 1'b1, 1'b0, 6'd5);
      beats(2);
      push_wr(7'd3, pl(1'b0, 6'd5, 6'd3));
      step(1'b1, 1'b1, 1'b1, 6'd6);
      beats(4);
      push_wr(7'd4, pl(1'b0, 6'd6, 6'd4));
      step(1'b0, 1'b0, 1'b1, 6'd0);
      step(1'b0, 1'b1, 1'b0, 6'd0);
      beats(2);
      push_wr(7'd5, pl(1'b1, 6'd0, 6'd2));
      step(1'b0, 1'b1, 1'b0, 6'd8);
      push_wr(7'd6, pl(1'b0, 6'd8, 6'd1));
      push_done(7'd6);
      set_rec(1'b0);
      idle(2);

      // 4: saturation of note and rest durations
      push_wr(7'd0, 16'h8000);
      set_rec(1'b1);
      step(1'b0, 1'b1, 1'b0, 6'd7);
      push_wr(7'd1, pl(1'b0, 6'd7, 6'd63));
      beats(70);
      push_wr(7'd2, pl(1'b0, 6'd7, 6'd7));
      step(1'b0, 1'b0, 1'b1, 6'd0);
      push_wr(7'd3, pl(1'b1, 6'd0, 6'd63));
      beats(63);
      step(1'b0, 1'b1, 1'b0, 6'd9);
      beats(2);
      push_wr(7'd4, pl(1'b0, 6'd9, 6'd2));
      step(1'b0, 1'b0, 1'b1, 6'd0);
      beats(3);
      push_done(7'd4);
      set_rec(1'b0);
      idle(2);

      // 5: fill the RAM
      push_wr(7'd0, 16'h8000);
      set_rec(1'b1);
      for (int unsigned i = 1; i <= 127; i++) begin
         n = 6'((i % 63) + 1);
         step(1'b0, 1'b1, 1'b0, n);
         push_wr(7'(i), pl(1'b0, n, 6'd1));
         if (i == 127) push_done(7'd127);
         step(1'b0, 1'b0, 1'b1, 6'd0);
      end
      idle(1);
      chk("t5_last", 32'(last_address), 32'd127);
      for (int unsigned i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 6'd4);
         step(1'b1, 1'b0, 1'b1, 6'd0);
      end
      chk("t5_full_recording", 32'(recording), 32'd1);
      set_rec(1'b0);
      idle(2);
      chk("t5_idle", 32'(recording), 32'd0);
      chk("t5_last_held", 32'(last_address), 32'd127);
      push_wr(7'd0, 16'h8000);
      set_rec(1'b1);
      push_done(7'd0);
      set_rec(1'b0);
      idle(2);

      // 6: reset mid-note
      push_wr(7'd0, 16'h8000);
      set_rec(1'b1);
      step(1'b0, 1'b1, 1'b0, 6'd3);
      beats(2);
      reset = 1'b1;
      record = 1'b0;
      #2;
      chk("t6_we",   32'(write_enable),   32'd0);
      chk("t6_done", 32'(done_recording), 32'd0);
      chk("t6_last", 32'(last_address),   32'd0);
      chk("t6_rec",  32'(recording),      32'd0);
      chk("t6_addr", 32'(write_address),  32'd0);
      chk("t6_pay",  32'(write_payload),  32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(3);
      chk("t6_after_rec", 32'(recording), 32'd0);

      idle(3);
      chk("pending_writes", 32'(exp_wr.size()),   32'd0);
      chk("pending_done",   32'(exp_done.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
